execute_cc_stage: RTL and testbench
===================================

// Module: execute_cc_stage
// PURPOSE
//  Y86-64 pipeline execute stage: consumer side of the ALU operand interface. Takes the E pipeline
//  register, selects aluA/aluB, drives the 64-bit ALU (add/sub/and/xor), and maintains the CC register.
//  Evaluates Cnd for cmovXX/jXX and registers results into the E->M pipeline register with stall/bubble.
//  Sits between the decode/E-register logic and the memory stage. Feeds forwarding paths (e_valE, e_dstE).
// PARAMETERS
//  DATA_W   64     datapath width; only 64 is supported.
//  RNONE    4'hF   register id meaning "no destination".
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       synchronous, active-high reset
//  E_stat    in   4       status of instr in E (AOK=1, HLT=2, ADR=3, INS=4)
//  E_icode   in   4       instruction code
//  E_ifun    in   4       function code (ALU op / condition)
//  E_valC    in   64      constant word
//  E_valA    in   64      operand A
//  E_valB    in   64      operand B
//  E_dstE    in   4       ALU-result dest reg
//  E_dstM    in   4       memory-result dest reg
//  cc_block  in   1       1 = m_stat or W_stat exceptional; inhibit CC update
//  M_stall   in   1       hold M register
//  M_bubble  in   1       load NOP bubble into M register
//  e_valE    out  64      comb ALU result (forwarding)
//  e_dstE    out  4       comb dest after cmov squash (forwarding)
//  e_cnd     out  1       comb condition result
//  cc_zf, cc_sf, cc_of  out 1 each   CC register
//  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM   out   4,4,1,64,64,4,4   M pipeline register
// BEHAVIOUR
//  - icodes: 0 halt,1 nop,2 rrmovq/cmov,3 irmovq,4 rmmovq,5 mrmovq,6 OPq,7 jXX,8 call,9 ret,A push,B pop.
//  - aluA: valA {2,6}; valC {3,4,5}; -8 {8,A}; +8 {9,B}; else 0.
//  - aluB: valB {4,5,6,8,9,A,B}; 0 {2,3}; else 0.
//  - alufun = E_ifun when icode=6, else ADD. ifun 0 add, 1 sub (B-A), 2 and, 3 xor.
//  - ifun>3 on OPq: result 0, no CC update; stat is set upstream.
//  - e_valE = aluB op aluA, mod 2^64, combinational.
//  - Flags: ZF = (valE==0); SF = valE[63].
//    OF(add) = (A[63]==B[63]) & (valE[63]!=A[63]). OF(sub) = (A[63]!=B[63]) & (valE[63]!=B[63]).
//    OF(and/xor) = 0.
//  - set_cc = (icode==6) & (ifun<=3) & (E_stat==AOK) & ~cc_block. CC loads on the next clk when set_cc=1.
//  - Cnd from the current CC register, not from this instr's flags:
//    ifun 0 =1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; >6 =0.
//  - e_cnd = Cnd for icode {2,7}, else 0. e_dstE = RNONE when icode=2 & ~e_cnd, else E_dstE.
//  - M register update priority each clk: rst > M_stall (hold all) > M_bubble > normal load.
//    M_bubble loads icode=1, stat=AOK, dstE=dstM=RNONE, cnd=0, valE=valA=0.
//  - Reset: M register = bubble values; CC: ZF=1, SF=0, OF=0. Reset mid-operation discards the in-flight instr.
//  - Latency: e_* combinational (0 cycles); M_* valid 1 clk after E presents the instr.
//  - Stall/bubble on CC: CC updates depend only on set_cc; the E register owner must bubble E if needed.
//  - Simultaneous M_stall & M_bubble: stall wins.
// STRUCTURE
//  - y86_defs.vh (shared include): icode/ifun/alufun/stat/RNONE constants; used by all stages.
//  - Sub-module alu64: comb 64-bit add/sub/and/xor plus ZF/SF/OF.
//  - This module: operand muxes, CC register, cond eval, M register.
// TESTING
//  - rst=1 for one clk -> M_icode=1, M_stat=1, M_dstE=F, ZF=1, SF=0, OF=0.
//  - OPq add: A=0x7FFFFFFFFFFFFFFF, B=1 -> valE=0x8000000000000000. Next clk: ZF=0, SF=1, OF=1.
//  - OPq sub: A=5, B=5 -> valE=0, ZF=1. Then cmovne (icode=2, ifun=4), dstE=3 -> e_cnd=0, e_dstE=F.
//  - OPq and with cc_block=1 -> valE correct; CC unchanged. Same instr with E_stat=HLT -> CC unchanged.
//  - pushq: valB=0x100 -> valE=0xF8. popq: valB=0xF8 -> valE=0x100. irmovq: valC=0x1234 -> valE=0x1234.
//  - Handshake: M_stall=1 for 2 clks -> M_* hold. M_stall=1 with M_bubble=1 -> hold. M_bubble alone -> NOP loaded.

Source files
------------

// File: rtl/execute_cc_stage_pkg.sv
// Shared Y86-64 execute-stage definitions: instruction/status codes, ALU function
// encoding, condition-code layout and the jXX/cmovXX condition evaluator.
package execute_cc_stage_pkg;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alufun_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Condition for jXX/cmovXX, evaluated against the committed CC register.
    function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = lt | cc.zf;
            4'd2:    cond_eval = lt;
            4'd3:    cond_eval = cc.zf;
            4'd4:    cond_eval = ~cc.zf;
            4'd5:    cond_eval = ~lt;
            4'd6:    cond_eval = ~lt & ~cc.zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_cc_stage_alu64.sv
// Combinational ALU: computes B op A (add/sub/and/xor) and the ZF/SF/OF flags.
// A disabled operation yields a zero result.
module execute_cc_stage_alu64
    import execute_cc_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  alufun_e                  fun_i,
    input  logic                     en_i,
    output logic signed [DATA_W-1:0] val_o,
    output cc_t                      flags_o
);

    logic signed [DATA_W-1:0] res;
    logic                     a_msb, b_msb, r_msb;

    always_comb begin
        res = '0;
        if (en_i) begin
            case (fun_i)
                ALU_ADD: res = b_i + a_i;
                ALU_SUB: res = b_i - a_i;
                ALU_AND: res = b_i & a_i;
                ALU_XOR: res = b_i ^ a_i;
                default: res = '0;
            endcase
        end
    end

    assign a_msb = a_i[DATA_W-1];
    assign b_msb = b_i[DATA_W-1];
    assign r_msb = res[DATA_W-1];

    always_comb begin
        flags_o.zf = (res == '0);
        flags_o.sf = r_msb;
        case (fun_i)
            ALU_ADD: flags_o.of = (a_msb == b_msb) & (r_msb != a_msb);
            ALU_SUB: flags_o.of = (a_msb != b_msb) & (r_msb != b_msb);
            default: flags_o.of = 1'b0;
        endcase
    end

    assign val_o = res;

endmodule

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: ALU operand selection, CC register, Cnd evaluation and
// the E->M pipeline register with stall/bubble control.
module execute_cc_stage
    import execute_cc_stage_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [DATA_W-1:0] E_valC,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [DATA_W-1:0] E_valB,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic              cc_block,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [DATA_W-1:0] e_valE,
    output logic [3:0]        e_dstE,
    output logic              e_cnd,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of,
    output logic [3:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);

    typedef struct packed {
        logic [3:0]        stat;
        logic [3:0]        icode;
        logic              cnd;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valA;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
    } m_reg_t;

    localparam m_reg_t M_NOP = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                 valE: '0, valA: '0, dstE: RNONE, dstM: RNONE};

    localparam logic signed [DATA_W-1:0] EIGHT = DATA_W'(8);

    logic signed [DATA_W-1:0] alu_a, alu_b, alu_val;
    alufun_e                  alu_fun;
    logic                     is_op, op_ok, alu_en, set_cc, cnd;
    cc_t                      alu_flags, cc_d, cc_q;
    m_reg_t                   m_d, m_q;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = $signed(E_valA);
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = $signed(E_valC);
            I_CALL, I_PUSHQ:             alu_a = -EIGHT;
            I_RET, I_POPQ:               alu_a = EIGHT;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ:
                alu_b = $signed(E_valB);
            default:
                alu_b = '0;
        endcase
    end

    // Only OPq selects a non-add function; an out-of-range OPq ifun zeroes the result.
    assign is_op   = (E_icode == I_OPQ);
    assign op_ok   = (E_ifun <= 4'd3);
    assign alu_fun = is_op ? alufun_e'(E_ifun[1:0]) : ALU_ADD;
    assign alu_en  = ~is_op | op_ok;

    execute_cc_stage_alu64 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i     (alu_a),
        .b_i     (alu_b),
        .fun_i   (alu_fun),
        .en_i    (alu_en),
        .val_o   (alu_val),
        .flags_o (alu_flags)
    );

    assign set_cc = is_op & op_ok & (E_stat == STAT_AOK) & ~cc_block;
    assign cc_d   = set_cc ? alu_flags : cc_q;

    always_ff @(posedge clk) begin
        if (rst) cc_q <= CC_RESET;
        else     cc_q <= cc_d;
    end

    // Cnd looks at the CC from earlier instructions, never this one's flags.
    assign cnd    = cond_eval(cc_q, E_ifun);
    assign e_cnd  = ((E_icode == I_RRMOVQ) | (E_icode == I_JXX)) & cnd;
    assign e_dstE = ((E_icode == I_RRMOVQ) & ~e_cnd) ? RNONE : E_dstE;
    assign e_valE = alu_val;

    always_comb begin
        m_d = m_q;
        if (!M_stall) begin
            if (M_bubble) begin
                m_d = M_NOP;
            end else begin
                m_d.stat  = E_stat;
                m_d.icode = E_icode;
                m_d.cnd   = e_cnd;
                m_d.valE  = e_valE;
                m_d.valA  = E_valA;
                m_d.dstE  = e_dstE;
                m_d.dstM  = E_dstM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) m_q <= M_NOP;
        else     m_q <= m_d;
    end

    assign cc_zf   = cc_q.zf;
    assign cc_sf   = cc_q.sf;
    assign cc_of   = cc_q.of;
    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Bench for execute_cc_stage: an instruction-level reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_execute_cc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        cc_block, M_stall, M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_cnd, cc_zf, cc_sf, cc_of, M_cnd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_cc_stage #(.DATA_W(64), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .cc_block(cc_block), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic        model_ok = 1'b0;
    logic [2:0]  mcc;            // {zf, sf, of}
    logic [3:0]  mM_stat, mM_icode, mM_dstE, mM_dstM;
    logic        mM_cnd;
    logic [63:0] mM_valE, mM_valA;

    function automatic logic [63:0] mdl_valE();
        case (E_icode)
            4'h2: return E_valA;
            4'h3: return E_valC;
            4'h4, 4'h5: return E_valB + E_valC;
            4'h6: case (E_ifun)
                      4'd0: return E_valB + E_valA;
                      4'd1: return E_valB - E_valA;
                      4'd2: return E_valB & E_valA;
                      4'd3: return E_valB ^ E_valA;
                      default: return 64'd0;
                  endcase
            4'h8, 4'hA: return E_valB - 64'd8;
            4'h9, 4'hB: return E_valB + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [2:0] mdl_flags();
        logic [63:0] v;
        logic [64:0] w;
        logic        of;
        v  = mdl_valE();
        of = 1'b0;
        if (E_ifun == 4'd0) begin
            w  = {E_valB[63], E_valB} + {E_valA[63], E_valA};
            of = w[64] ^ w[63];
        end else if (E_ifun == 4'd1) begin
            w  = {E_valB[63], E_valB} - {E_valA[63], E_valA};
            of = w[64] ^ w[63];
        end
        return {v == 64'd0, v[63], of};
    endfunction

    function automatic logic mdl_setcc();
        return (E_icode == 4'h6) && (E_ifun <= 4'd3) && (E_stat == 4'd1) && !cc_block;
    endfunction

    function automatic logic mdl_ecnd();
        logic zf, sf, of, c;
        {zf, sf, of} = mcc;
        case (E_ifun)
            4'd0: c = 1'b1;
            4'd1: c = (sf != of) || zf;
            4'd2: c = (sf != of);
            4'd3: c = zf;
            4'd4: c = !zf;
            4'd5: c = (sf == of);
            4'd6: c = (sf == of) && !zf;
            default: c = 1'b0;
        endcase
        return ((E_icode == 4'h2) || (E_icode == 4'h7)) && c;
    endfunction

    function automatic logic [3:0] mdl_edstE();
        return ((E_icode == 4'h2) && !mdl_ecnd()) ? 4'hF : E_dstE;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            mcc      <= 3'b100;
            mM_stat <= 4'd1; mM_icode <= 4'd1; mM_cnd <= 1'b0;
            mM_valE <= 64'd0; mM_valA <= 64'd0; mM_dstE <= 4'hF; mM_dstM <= 4'hF;
        end else begin
            if (mdl_setcc()) mcc <= mdl_flags();
            if (!M_stall) begin
                if (M_bubble) begin
                    mM_stat <= 4'd1; mM_icode <= 4'd1; mM_cnd <= 1'b0;
                    mM_valE <= 64'd0; mM_valA <= 64'd0; mM_dstE <= 4'hF; mM_dstM <= 4'hF;
                end else begin
                    mM_stat <= E_stat; mM_icode <= E_icode; mM_cnd <= mdl_ecnd();
                    mM_valE <= mdl_valE(); mM_valA <= E_valA;
                    mM_dstE <= mdl_edstE(); mM_dstM <= E_dstM;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("e_valE", e_valE, mdl_valE());
            check("e_dstE", {60'd0, e_dstE}, {60'd0, mdl_edstE()});
            check("e_cnd", {63'd0, e_cnd}, {63'd0, mdl_ecnd()});
            check("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, mcc});
            check("M_stat", {60'd0, M_stat}, {60'd0, mM_stat});
            check("M_icode", {60'd0, M_icode}, {60'd0, mM_icode});
            check("M_cnd", {63'd0, M_cnd}, {63'd0, mM_cnd});
            check("M_valE", M_valE, mM_valE);
            check("M_valA", M_valA, mM_valA);
            check("M_dstE", {60'd0, M_dstE}, {60'd0, mM_dstE});
            check("M_dstM", {60'd0, M_dstM}, {60'd0, mM_dstM});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] valC, input logic [63:0] valA, input logic [63:0] valB,
                         input logic [3:0] dstE, input logic [3:0] dstM);
        E_stat = stat; E_icode = icode; E_ifun = ifun;
        E_valC = valC; E_valA = valA; E_valB = valB;
        E_dstE = dstE; E_dstM = dstM;
    endtask

    task automatic check_cc(input string name, input logic [2:0] req);
        check(name, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, req});
    endtask

    logic [63:0] opa [8];
    logic [63:0] opb [8];

    initial begin
        rst = 1'b1; cc_block = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
        issue(4'd1, 4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick(); tick();
        rst = 1'b0;
        check("rst_M_icode", {60'd0, M_icode}, 64'd1);
        check("rst_M_stat", {60'd0, M_stat}, 64'd1);
        check("rst_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("rst_M_valE", M_valE, 64'd0);
        check_cc("rst_cc", 3'b100);

        // add overflow
        issue(4'd1, 4'h6, 4'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 4'hF);
        #2 check("add_valE", e_valE, 64'h8000_0000_0000_0000);
        tick();
        check_cc("add_cc", 3'b011);
        check("add_M_valE", M_valE, 64'h8000_0000_0000_0000);
        check("add_M_icode", {60'd0, M_icode}, 64'd6);

        // sub to zero, then cmovne must squash
        issue(4'd1, 4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd2, 4'hF);
        #2 check("sub_valE", e_valE, 64'd0);
        tick();
        check_cc("sub_cc", 3'b100);
        issue(4'd1, 4'h2, 4'd4, 64'd0, 64'd9, 64'd0, 4'd3, 4'hF);
        #2 check("cmovne_cnd", {63'd0, e_cnd}, 64'd0);
        check("cmovne_dstE", {60'd0, e_dstE}, 64'hF);
        tick();
        check("cmovne_M_dstE", {60'd0, M_dstE}, 64'hF);
        issue(4'd1, 4'h2, 4'd3, 64'd0, 64'd9, 64'd0, 4'd3, 4'hF);
        #2 check("cmove_dstE", {60'd0, e_dstE}, 64'd3);
        tick();

        // and: blocked, then HLT, then allowed
        cc_block = 1'b1;
        issue(4'd1, 4'h6, 4'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0000_0000_003C, 4'd2, 4'hF);
        #2 check("and_valE", e_valE, 64'h8000_0000_0000_0030);
        tick();
        check_cc("and_blocked_cc", 3'b100);
        cc_block = 1'b0;
        E_stat = 4'd2;
        tick();
        check_cc("and_hlt_cc", 3'b100);
        E_stat = 4'd1;
        tick();
        check_cc("and_set_cc", 3'b010);

        // OPq with ifun>3: zero result, CC untouched
        issue(4'd1, 4'h6, 4'd5, 64'd0, 64'd3, 64'd4, 4'd2, 4'hF);
        #2 check("badop_valE", e_valE, 64'd0);
        tick();
        check_cc("badop_cc", 3'b010);

        // jXX against CC {zf=0, sf=1, of=0}
        issue(4'd1, 4'h7, 4'd2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        #2 check("jl_cnd", {63'd0, e_cnd}, 64'd1);
        tick();
        issue(4'd1, 4'h7, 4'd6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        #2 check("jg_cnd", {63'd0, e_cnd}, 64'd0);
        tick();

        // stack / immediate address arithmetic
        issue(4'd1, 4'hA, 4'd0, 64'd0, 64'd7, 64'h100, 4'd4, 4'hF);
        #2 check("push_valE", e_valE, 64'hF8);
        tick();
        issue(4'd1, 4'hB, 4'd0, 64'd0, 64'd0, 64'hF8, 4'd4, 4'd5);
        #2 check("pop_valE", e_valE, 64'h100);
        tick();
        issue(4'd1, 4'h3, 4'd0, 64'h1234, 64'd0, 64'd0, 4'd6, 4'hF);
        #2 check("irmov_valE", e_valE, 64'h1234);
        tick();
        issue(4'd1, 4'h4, 4'd0, 64'h10, 64'd1, 64'h20, 4'hF, 4'hF);
        #2 check("rmmov_valE", e_valE, 64'h30);
        tick();
        issue(4'd1, 4'h8, 4'd0, 64'h500, 64'd0, 64'h200, 4'd4, 4'hF);
        #2 check("call_valE", e_valE, 64'h1F8);
        tick();

        // OPq sweep of boundary operands, checked by the model
        opa = '{64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                64'd0, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 64'd1};
        opb = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 64'd1, 64'h0FED_CBA9_8765_4321, 64'h7FFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            for (int f = 0; f < 4; f++) begin
                issue(4'd1, 4'h6, 4'(f), 64'd0, opa[i], opb[i], 4'd1, 4'hF);
                tick();
                for (int c = 0; c < 7; c++) begin
                    issue(4'd1, (c % 2 == 0) ? 4'h7 : 4'h2, 4'(c), 64'd0, 64'd3, 64'd0, 4'd2, 4'hF);
                    #2;
                end
                tick();
            end
        end
        issue(4'd1, 4'h6, 4'd1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'd1, 4'hF);
        tick();
        check_cc("sub_of_cc", 3'b001);

        // stall / bubble handshake
        issue(4'd1, 4'h3, 4'd0, 64'h55, 64'd0, 64'd0, 4'd4, 4'hF);
        tick();
        check("pre_stall_valE", M_valE, 64'h55);
        M_stall = 1'b1;
        issue(4'd1, 4'h3, 4'd0, 64'h66, 64'd0, 64'd0, 4'd5, 4'hF);
        tick(); tick();
        check("stall_valE", M_valE, 64'h55);
        check("stall_dstE", {60'd0, M_dstE}, 64'd4);
        M_bubble = 1'b1;
        tick();
        check("stall_bubble_valE", M_valE, 64'h55);
        M_stall = 1'b0;
        tick();
        check("bubble_icode", {60'd0, M_icode}, 64'd1);
        check("bubble_valE", M_valE, 64'd0);
        check("bubble_dstE", {60'd0, M_dstE}, 64'hF);
        M_bubble = 1'b0;
        tick();
        check("resume_valE", M_valE, 64'h66);

        // reset mid-operation discards the in-flight instruction
        issue(4'd1, 4'h6, 4'd0, 64'd0, 64'd1, 64'd1, 4'd2, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_icode", {60'd0, M_icode}, 64'd1);
        check_cc("midrst_cc", 3'b100);
        issue(4'd1, 4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
